// File: rtl/uart_imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package uart_imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_ADDR,
    S_DATA,
    S_CSUM,
    S_RESP
  } loader_state_e;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEF_ACK_BYTE  = 8'h06;
  localparam logic [7:0] DEF_NAK_BYTE  = 8'h15;

  // Header field sizes in bytes
  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned ADDR_BYTES = 4;

endpackage

// File: rtl/uart_imem_loader.sv
// Receives a framed program image over UART RX, writes it word-by-word into
// instruction memory, holds the CPU in reset while loading and answers
// with a one-byte ACK/NAK.
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter logic [7:0]  ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0]  NAK_BYTE       = DEF_NAK_BYTE,
  parameter int unsigned MAX_WORDS      = 32768,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_mem_en,
  output logic [3:0]  o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wrdata,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_cpu_hold,
  output logic        o_load_done
);

  loader_state_e state_q, state_d;

  logic [1:0]  byte_cnt_q;
  logic [15:0] len_q;        // word count, then words still to receive
  logic [31:0] addr_q;
  logic [23:0] word_q;       // lower three bytes of the word being assembled
  logic [7:0]  sum_q;
  logic [31:0] tcnt_q;
  logic        resp_ack_q;
  logic [7:0]  tx_data_q;
  logic        mem_en_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wrdata_q;
  logic        cpu_hold_q;
  logic        load_done_q;

  logic        accept;
  logic        active;
  logic        timeout_hit;
  logic        len_last;
  logic        addr_last;
  logic        word_last;
  logic [15:0] n_len;
  logic        oversize;
  logic        csum_ok;

  assign accept      = i_rx_valid && (state_q != S_RESP);
  assign active      = (state_q == S_LEN) || (state_q == S_ADDR) ||
                       (state_q == S_DATA) || (state_q == S_CSUM);
  assign timeout_hit = active && !accept && (tcnt_q == TIMEOUT_CYCLES - 32'd1);
  assign len_last    = (byte_cnt_q == 2'(LEN_BYTES - 1));
  assign addr_last   = (byte_cnt_q == 2'(ADDR_BYTES - 1));
  assign word_last   = (byte_cnt_q == 2'd3);
  assign n_len       = {i_rx_data, len_q[15:8]};
  assign oversize    = ({16'd0, n_len} > MAX_WORDS);
  assign csum_ok     = (state_q == S_CSUM) && accept && (i_rx_data == sum_q);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a timeout overrides whatever the byte path decided
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept && (i_rx_data == SYNC_BYTE)) state_d = S_LEN;
      S_LEN:  if (accept && len_last) state_d = oversize ? S_RESP : S_ADDR;
      S_ADDR: if (accept && addr_last) state_d = (len_q == '0) ? S_CSUM : S_DATA;
      S_DATA: if (accept && word_last && (len_q == 16'd1)) state_d = S_CSUM;
      S_CSUM: if (accept) state_d = S_RESP;
      S_RESP: if (i_tx_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (timeout_hit) state_d = S_RESP;
  end

  // Field assembly, checksum, timeout counter, write strobe and response
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      byte_cnt_q   <= '0;
      len_q        <= '0;
      addr_q       <= '0;
      word_q       <= '0;
      sum_q        <= '0;
      tcnt_q       <= '0;
      resp_ack_q   <= 1'b0;
      tx_data_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wrdata_q <= '0;
      cpu_hold_q   <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      mem_en_q    <= 1'b0;
      load_done_q <= 1'b0;

      if (active && !accept) tcnt_q <= tcnt_q + 32'd1;
      else                   tcnt_q <= '0;

      unique case (state_q)
        S_IDLE: begin
          if (accept && (i_rx_data == SYNC_BYTE)) begin
            cpu_hold_q <= 1'b1;
            sum_q      <= '0;
            byte_cnt_q <= '0;
          end
        end
        S_LEN: begin
          if (accept) begin
            len_q      <= n_len;
            sum_q      <= sum_q + i_rx_data;
            byte_cnt_q <= len_last ? '0 : byte_cnt_q + 2'd1;
          end
        end
        S_ADDR: begin
          if (accept) begin
            // The low address bits are dropped as the last byte lands
            addr_q     <= addr_last ? {i_rx_data, addr_q[31:10], 2'b00}
                                    : {i_rx_data, addr_q[31:8]};
            sum_q      <= sum_q + i_rx_data;
            byte_cnt_q <= addr_last ? '0 : byte_cnt_q + 2'd1;
          end
        end
        S_DATA: begin
          if (accept) begin
            sum_q      <= sum_q + i_rx_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            word_q     <= {i_rx_data, word_q[23:8]};
            if (word_last) begin
              mem_en_q     <= 1'b1;
              mem_addr_q   <= addr_q;
              mem_wrdata_q <= {i_rx_data, word_q};
              addr_q       <= addr_q + 32'd4;
              len_q        <= len_q - 16'd1;
            end
          end
        end
        S_RESP: begin
          if (i_tx_ready && resp_ack_q) begin
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b1;
          end
        end
        default: ;
      endcase

      if ((state_d == S_RESP) && (state_q != S_RESP)) begin
        resp_ack_q <= csum_ok;
        tx_data_q  <= csum_ok ? ACK_BYTE : NAK_BYTE;
      end
    end
  end

  assign o_rx_ready   = (state_q != S_RESP);
  assign o_tx_valid   = (state_q == S_RESP);
  assign o_tx_data    = tx_data_q;
  assign o_mem_en     = mem_en_q;
  assign o_mem_we     = {4{mem_en_q}};
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_wrdata = mem_wrdata_q;
  assign o_cpu_hold   = cpu_hold_q;
  assign o_load_done  = load_done_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed, table-driven bench for uart_imem_loader.
module tb_uart_imem_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wrdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        cpu_hold;
  logic        load_done;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;

  uart_imem_loader #(
    .MAX_WORDS      (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_rx_ready   (rx_ready),
    .o_mem_en     (mem_en),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wrdata (mem_wrdata),
    .o_tx_data    (tx_data),
    .o_tx_valid   (tx_valid),
    .i_tx_ready   (tx_ready),
    .o_cpu_hold   (cpu_hold),
    .o_load_done  (load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (mem_en === 1'b1) wr_count++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  b;
    logic        hold;
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
    logic        txv;
    logic [7:0]  txd;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic [7:0] b, logic h, logic en, logic [31:0] a,
                              logic [31:0] d, logic tv, logic [7:0] td);
    vec_t v;
    v.b = b; v.hold = h; v.en = en; v.addr = a; v.data = d; v.txv = tv; v.txd = td;
    vq.push_back(v);
  endfunction

  function automatic void pb(logic [7:0] b);
    add(b, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      rx_data  = vq[i].b;
      rx_valid = 1'b1;
      check($sformatf("v%0d rx_ready", i), 32'(rx_ready), 32'd1);
      @(posedge clk); #1;
      check($sformatf("v%0d cpu_hold", i), 32'(cpu_hold), 32'(vq[i].hold));
      check($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(vq[i].en));
      check($sformatf("v%0d mem_we", i), 32'(mem_we), vq[i].en ? 32'hF : 32'h0);
      check($sformatf("v%0d tx_valid", i), 32'(tx_valid), 32'(vq[i].txv));
      if (vq[i].en) begin
        check($sformatf("v%0d mem_addr", i), mem_addr, vq[i].addr);
        check($sformatf("v%0d mem_wrdata", i), mem_wrdata, vq[i].data);
      end
      if (vq[i].txv) check($sformatf("v%0d tx_data", i), 32'(tx_data), 32'(vq[i].txd));
    end
    rx_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " mem_en"}, 32'(mem_en), 32'd0);
    check({tag, " mem_we"}, 32'(mem_we), 32'd0);
    check({tag, " mem_addr"}, mem_addr, 32'd0);
    check({tag, " mem_wrdata"}, mem_wrdata, 32'd0);
    check({tag, " tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, " tx_data"}, 32'(tx_data), 32'd0);
    check({tag, " cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, " load_done"}, 32'(load_done), 32'd0);
    check({tag, " rx_ready"}, 32'(rx_ready), 32'd1);
  endtask

  task automatic handshake(input string tag, input logic ack);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    check({tag, " tx_valid after hs"}, 32'(tx_valid), 32'd0);
    check({tag, " rx_ready after hs"}, 32'(rx_ready), 32'd1);
    check({tag, " load_done"}, 32'(load_done), 32'(ack));
    check({tag, " cpu_hold after hs"}, 32'(cpu_hold), 32'(!ack));
    if (ack) begin
      @(posedge clk); #1;
      check({tag, " load_done single"}, 32'(load_done), 32'd0);
    end
  endtask

  int m_good, m_bad, m_zero, m_over, m_tmo, m_bnd, m_end;
  int k;

  initial begin
    // Good frame: two words to 0x100, checksum 0x85
    m_good = vq.size();
    pb(8'hA5); pb(8'h02); pb(8'h00);
    pb(8'h00); pb(8'h01); pb(8'h00); pb(8'h00);
    pb(8'h13); pb(8'h00); pb(8'h00);
    add(8'h00, 1'b1, 1'b1, 32'h100, 32'h13, 1'b0, 8'h00);
    pb(8'h6F); pb(8'h00); pb(8'h00);
    add(8'h00, 1'b1, 1'b1, 32'h104, 32'h6F, 1'b0, 8'h00);
    add(8'h85, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 8'h06);
    // Same frame, bad checksum
    m_bad = vq.size();
    pb(8'hA5); pb(8'h02); pb(8'h00);
    pb(8'h00); pb(8'h01); pb(8'h00); pb(8'h00);
    pb(8'h13); pb(8'h00); pb(8'h00);
    add(8'h00, 1'b1, 1'b1, 32'h100, 32'h13, 1'b0, 8'h00);
    pb(8'h6F); pb(8'h00); pb(8'h00);
    add(8'h00, 1'b1, 1'b1, 32'h104, 32'h6F, 1'b0, 8'h00);
    add(8'h84, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 8'h15);
    // Zero-length frame
    m_zero = vq.size();
    pb(8'hA5);
    for (int i = 0; i < 6; i++) pb(8'h00);
    add(8'h00, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 8'h06);
    // Oversize LEN (5 > 4)
    m_over = vq.size();
    pb(8'hA5); pb(8'h05);
    add(8'h00, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 8'h15);
    // Timeout: header stalls after first LEN byte
    m_tmo = vq.size();
    pb(8'hA5); pb(8'h02);
    // LEN == MAX_WORDS accepted, unaligned ADDR 0x203 forced to 0x200
    m_bnd = vq.size();
    pb(8'hA5); pb(8'h04); pb(8'h00);
    pb(8'h03); pb(8'h02); pb(8'h00); pb(8'h00);
    pb(8'h11); pb(8'h22); pb(8'h33);
    add(8'h44, 1'b1, 1'b1, 32'h200, 32'h44332211, 1'b0, 8'h00);
    pb(8'h55); pb(8'h66);
    m_end = vq.size();

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    apply(m_good, m_bad);
    handshake("good", 1'b1);

    apply(m_bad, m_zero);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d tx_valid", i), 32'(tx_valid), 32'd1);
      check($sformatf("bp%0d tx_data", i), 32'(tx_data), 32'h15);
      check($sformatf("bp%0d rx_ready", i), 32'(rx_ready), 32'd0);
    end
    handshake("badcsum", 1'b0);

    apply(m_zero, m_over);
    handshake("zero", 1'b1);

    apply(m_over, m_tmo);
    handshake("oversize", 1'b0);

    apply(m_tmo, m_bnd);
    k = 0;
    while (tx_valid !== 1'b1 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check("timeout cycles", 32'(k), 32'd100);
    check("timeout tx_data", 32'(tx_data), 32'h15);
    handshake("timeout", 1'b0);

    apply(m_bnd, m_end);
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
    @(posedge clk); #1;
    check_reset("midframe reset");
    rst = 1'b0; rx_valid = 1'b0;
    @(posedge clk); #1;
    check("post reset tx_valid", 32'(tx_valid), 32'd0);

    check("total writes", 32'(wr_count), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
